fetch_stage: RTL and testbench

Instruction-fetch stage of the RISC-V core, sitting directly upstream of the decode and control logic. Holds the PC and drives a synchronous instruction memory with one-cycle read latency. Presents a valid {pc, instruction} pair to decode each cycle. Handles pipeline stall, branch/jump redirect and halt without dropping or duplicating instructions.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_if.sv | 45 ++++
 rtl/fetch_skid_buf.sv | 32 +++
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The per-cycle action enum names the outcome of the redirect/stall/halt priority decision.
package fetch_stage_pkg;

    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_IMEM_AW  = 9;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [2:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_HALT,
        ACT_REDIRECT,
        ACT_FROZEN
    } fetch_act_e;

endpackage

// File: rtl/fetch_if.sv
// Bundle between the fetch stage, its instruction memory and the decode/execute controls.
// The master side is the fetch stage; the slave side is the surrounding pipeline and memory.
interface fetch_if #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 9
);

    logic              stall;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic              halt;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rd_data;
    logic [DATA_W-1:0] ifid_pc;
    logic [DATA_W-1:0] ifid_instr;
    logic              ifid_valid;
    logic [DATA_W-1:0] fetch_pc;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  halt,
        input  imem_rd_data,
        output imem_addr,
        output ifid_pc,
        output ifid_instr,
        output ifid_valid,
        output fetch_pc
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output halt,
        output imem_rd_data,
        input  imem_addr,
        input  ifid_pc,
        input  ifid_instr,
        input  ifid_valid,
        input  fetch_pc
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// Holds the instruction word read during the first stall cycle, since the memory
// output moves on to the next address while the PC is frozen.
module fetch_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              flush,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] hold_instr_q,
    output logic              hold_valid_q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid_q <= 1'b0;
        end else if (flush) begin
            hold_valid_q <= 1'b0;
        end else if (capture) begin
            hold_valid_q <= 1'b1;
        end
    end

    // Data word is only ever observed while hold_valid_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_instr_q <= rd_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a one-cycle-latency instruction memory
// and presents {pc, instruction, valid} to decode, honouring redirect > stall > halt.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              DATA_W   = DEF_DATA_W,
    parameter int              IMEM_AW  = DEF_IMEM_AW,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEF_RESET_PC)
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master bus
);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] f2_pc_q, f2_pc_d;
    logic              f2_valid_q, f2_valid_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] hold_instr_q;
    logic              hold_valid_q;
    logic              skid_capture;
    logic              skid_flush;
    fetch_act_e        act;

    always_comb begin
        act = ACT_ADVANCE;
        if (halted_q) begin
            act = ACT_FROZEN;
        end else if (bus.redirect) begin
            act = ACT_REDIRECT;
        end else if (bus.stall) begin
            act = ACT_STALL;
        end else if (bus.halt) begin
            act = ACT_HALT;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        f2_pc_d      = f2_pc_q;
        f2_valid_d   = f2_valid_q;
        skid_capture = 1'b0;
        skid_flush   = 1'b0;
        halted_d     = halted_q | bus.halt;
        case (act)
            ACT_ADVANCE: begin
                pc_d       = pc_q + DATA_W'(4);
                f2_pc_d    = pc_q;
                f2_valid_d = 1'b1;
                skid_flush = 1'b1;
            end
            // Only the first stall cycle sees the word matching f2_pc_q on the memory output.
            ACT_STALL: begin
                skid_capture = f2_valid_q & ~hold_valid_q;
            end
            ACT_REDIRECT: begin
                pc_d       = bus.redirect_pc & ~DATA_W'(3);
                f2_valid_d = 1'b0;
                skid_flush = 1'b1;
            end
            ACT_HALT, ACT_FROZEN: begin
                f2_valid_d = 1'b0;
                skid_flush = 1'b1;
            end
            default: begin
                f2_valid_d = 1'b0;
                skid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            f2_pc_q    <= '0;
            f2_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            f2_pc_q    <= f2_pc_d;
            f2_valid_q <= f2_valid_d;
            halted_q   <= halted_d;
        end
    end

    fetch_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk          (clk),
        .reset        (reset),
        .capture      (skid_capture),
        .flush        (skid_flush),
        .rd_data      (bus.imem_rd_data),
        .hold_instr_q (hold_instr_q),
        .hold_valid_q (hold_valid_q)
    );

    logic              out_valid;
    logic [DATA_W-1:0] out_instr;

    always_comb begin
        out_valid = hold_valid_q ? 1'b1 : f2_valid_q;
        out_instr = hold_valid_q ? hold_instr_q : bus.imem_rd_data;
        if (!out_valid) begin
            out_instr = DATA_W'(NOP_INSTR);
        end
    end

    assign bus.imem_addr  = pc_q[IMEM_AW+1:2];
    assign bus.ifid_pc    = f2_pc_q;
    assign bus.ifid_instr = out_instr;
    assign bus.ifid_valid = out_valid;
    assign bus.fetch_pc   = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a transaction-level model:
// the model tracks which PC is presented and derives the instruction from memory contents.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int          DW  = 32;
    localparam int          AW  = 9;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk;
    logic reset;
    fetch_if #(.DATA_W(DW), .IMEM_AW(AW)) bus ();

    fetch_stage #(.DATA_W(DW), .IMEM_AW(AW), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [1 << AW];
    always @(posedge clk) bus.imem_rd_data <= mem[bus.imem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: next fetch address, the presented pair, and sticky halt.
    logic [31:0] m_pc;
    logic [31:0] m_pres_pc;
    logic        m_pres_valid;
    logic        m_halted;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_at(input logic [31:0] addr);
        logic [AW-1:0] idx;
        idx = addr[AW+1:2];
        return mem[idx];
    endfunction

    task automatic model_reset();
        m_pc         = RPC;
        m_pres_pc    = 32'h0;
        m_pres_valid = 1'b0;
        m_halted     = 1'b0;
    endtask

    task automatic model_edge();
        if (m_halted) begin
            m_pres_valid = 1'b0;
        end else if (bus.redirect) begin
            m_pc         = bus.redirect_pc & 32'hFFFF_FFFC;
            m_pres_valid = 1'b0;
        end else if (bus.stall) begin
            // presented pair is held unchanged
        end else if (bus.halt) begin
            m_pres_valid = 1'b0;
        end else begin
            m_pres_pc    = m_pc;
            m_pres_valid = 1'b1;
            m_pc         = m_pc + 32'd4;
        end
        if (bus.halt) m_halted = 1'b1;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_instr;
        logic [AW-1:0] exp_addr;
        exp_instr = m_pres_valid ? mem_at(m_pres_pc) : NOP_INSTR;
        exp_addr  = m_pc[AW+1:2];
        check_val("ifid_valid", 32'(bus.ifid_valid), 32'(m_pres_valid));
        check_val("ifid_pc", bus.ifid_pc, m_pres_pc);
        check_val("ifid_instr", bus.ifid_instr, exp_instr);
        check_val("fetch_pc", bus.fetch_pc, m_pc);
        check_val("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_in(input logic st, input logic rd, input logic [31:0] rpc, input logic hl);
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt        = hl;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(bus.ifid_valid), 32'h0);
        check_val({tag, "_pc"}, bus.ifid_pc, 32'h0);
        check_val({tag, "_instr"}, bus.ifid_instr, NOP_INSTR);
        check_val({tag, "_fetch_pc"}, bus.fetch_pc, RPC);
    endtask

    // Drops reset between clock edges and checks that outputs react without a clock.
    task automatic async_reset_pulse(input string tag);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_reset_outputs(tag);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0]  = 32'hA000_00A1;
        mem[1]  = 32'hB000_00B2;
        mem[2]  = 32'hC000_00C3;
        mem[3]  = 32'hD000_00D4;
        mem[16] = 32'hE000_00E5;

        reset = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check_val("reset_imem_addr", 32'(bus.imem_addr), 32'h0);
        @(negedge clk) reset = 1'b1;

        // Straight-line fetch A..D
        step();
        check_val("first_pc", bus.ifid_pc, 32'h0);
        check_val("first_instr", bus.ifid_instr, 32'hA000_00A1);
        step();
        step();
        check_val("pc8_instr", bus.ifid_instr, 32'hC000_00C3);

        // Stall three cycles while {8,C} is presented
        set_in(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_hold_instr", bus.ifid_instr, 32'hC000_00C3);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check_val("release_pc", bus.ifid_pc, 32'd12);
        check_val("release_instr", bus.ifid_instr, 32'hD000_00D4);

        // Redirect to 0x40: one bubble, then target
        set_in(1'b0, 1'b1, 32'h40, 1'b0);
        step();
        check_val("redir_bubble", 32'(bus.ifid_valid), 32'h0);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check_val("redir_pc", bus.ifid_pc, 32'h40);
        check_val("redir_instr", bus.ifid_instr, 32'hE000_00E5);
        step();
        check_val("redir_next_pc", bus.ifid_pc, 32'h44);

        // Stall with a live hold, then redirect+stall to a misaligned target
        set_in(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        set_in(1'b1, 1'b1, 32'h23, 1'b0);
        step();
        check_val("rs_fetch_pc", bus.fetch_pc, 32'h20);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check_val("rs_pc", bus.ifid_pc, 32'h20);
        check_val("rs_instr", bus.ifid_instr, mem[8]);

        // PC wrap at the top of the address space
        set_in(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        step();
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check_val("wrap_fetch_pc", bus.fetch_pc, 32'h0);
        step();

        // Random mix of stalls and redirects, including targets that alias in memory
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 8191));
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, tgt, 1'b0);
            step();
        end

        // Async reset in the middle of a stall with a live hold
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        set_in(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        step();
        async_reset_pulse("midstall_rst");
        step();
        check_val("post_rst_pc", bus.ifid_pc, RPC);

        // Halt at pc=0x10, later redirect ignored
        async_reset_pulse("pre_halt_rst");
        for (int i = 0; i < 4; i++) step();
        check_val("halt_at_pc", bus.fetch_pc, 32'h10);
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        check_val("halt_valid", 32'(bus.ifid_valid), 32'h0);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        step();
        set_in(1'b0, 1'b1, 32'h80, 1'b0);
        step();
        check_val("halt_redir_ignored", bus.fetch_pc, 32'h10);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Halt and redirect in the same cycle
        async_reset_pulse("pre_hr_rst");
        step();
        step();
        set_in(1'b0, 1'b1, 32'h100, 1'b1);
        step();
        check_val("hr_fetch_pc", bus.fetch_pc, 32'h100);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check_val("hr_no_fetch", 32'(bus.ifid_valid), 32'h0);

        // Random traffic with halt possible
        async_reset_pulse("pre_rand_halt_rst");
        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                   32'($urandom_range(0, 4095)), $urandom_range(0, 99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
